// File: rtl/arena_compositor.sv
// N-player arena compositor: game-phase FSM, IR start decode, hit-flash timers, health bars
// and a 2-stage priority pixel pipeline. Optional pause mode: define ARENA_COMPOSITOR_PAUSE_EN.
module arena_compositor #(
   parameter int          NUM_PLAYERS  = 2,
   parameter int          HEALTH_W     = 3,
   parameter int          FLASH_FRAMES = 8,
   parameter int          OVER_FRAMES  = 120,
   parameter int          BORDER_X     = 960,
   parameter int          BORDER_Y     = 640,
   parameter int          HB_X0        = 200,
   parameter int          HB_DX        = 360,
   parameter int          HB_Y         = 20,
   parameter logic [31:0] START_KEY    = 32'h20DF_5BA4,
   parameter logic [31:0] ALT_KEY      = 32'h20DF_5AA5,
`ifdef ARENA_COMPOSITOR_PAUSE_EN
   parameter logic [31:0] PAUSE_KEY    = 32'h20DF_10EF,
`endif
   parameter logic [24*NUM_PLAYERS-1:0] PLAYER_COLORS = {24'hFF0000, 24'h0000FF}
) (
   input  logic                            clk_in,
   input  logic                            rst_in,
   input  logic                            nf_in,
   input  logic [10:0]                     hcount_in,
   input  logic [9:0]                      vcount_in,
   input  logic [31:0]                     ir_in,
   input  logic                            ir_valid_in,
   input  logic                            camera_sw,
   input  logic [23:0]                     camera_pixel_in,
   input  logic [23:0]                     start_pixel_in,
   input  logic [NUM_PLAYERS-1:0]          box_hit_in,
   input  logic [NUM_PLAYERS-1:0]          saber_hit_in,
   input  logic [2*NUM_PLAYERS-1:0]        saber_state_in,
   input  logic [HEALTH_W*NUM_PLAYERS-1:0] health_in,
   output logic [23:0]                     pixel_out,
   output logic [1:0]                      state_out,
   output logic [1:0]                      winner_out
);

   localparam int FW       = $clog2(FLASH_FRAMES + 1);
   localparam int OCW      = $clog2(OVER_FRAMES + 1);
   localparam int DEAD_MIN = (NUM_PLAYERS == 1) ? 1 : NUM_PLAYERS - 1;

   typedef enum logic [1:0] {
      ST_START = 2'd0,
      ST_PLAY  = 2'd1,
      ST_OVER  = 2'd2,
      ST_PAUSE = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [1:0]           winner_q, winner_d, winnerNext;
   logic [OCW-1:0]       overCnt_q, overCnt_d;
   logic [FW-1:0]        flash_q [NUM_PLAYERS];
   logic [FW-1:0]        flash_d [NUM_PLAYERS];
   logic [HEALTH_W-1:0]  prevHealth_q [NUM_PLAYERS];
   logic [HEALTH_W-1:0]  prevHealth_d [NUM_PLAYERS];
   logic [HEALTH_W-1:0]  health [NUM_PLAYERS];
   logic                 keyPress, pauseKey, overCond;
   int                   deadCnt;

   function automatic logic [23:0] halve(input logic [23:0] c);
      return {1'b0, c[23:17], 1'b0, c[15:9], 1'b0, c[7:1]};
   endfunction

   function automatic logic [23:0] saberColor(input logic [1:0] s);
      case (s)
         2'd0:    return 24'hFFFFFF;
         2'd2:    return 24'h0000FF;
         default: return 24'h00FF00;
      endcase
   endfunction

   assign keyPress = ir_valid_in && (ir_in == START_KEY || ir_in == ALT_KEY);
`ifdef ARENA_COMPOSITOR_PAUSE_EN
   assign pauseKey = ir_valid_in && (ir_in == PAUSE_KEY);
`else
   assign pauseKey = 1'b0;
`endif

   always_comb begin
      deadCnt    = 0;
      winnerNext = 2'd0;
      for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
         health[i] = health_in[i*HEALTH_W +: HEALTH_W];
         if (health[i] == '0) deadCnt = deadCnt + 1;
         else winnerNext = 2'(i);
      end
   end

   assign overCond = nf_in && (deadCnt >= DEAD_MIN);

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) state_q <= ST_START;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_START: if (keyPress) state_d = ST_PLAY;
         ST_PLAY: begin
            if (overCond)      state_d = ST_OVER;
            else if (pauseKey) state_d = ST_PAUSE;
         end
         ST_OVER:  if (nf_in && overCnt_q == OCW'(1)) state_d = ST_START;
         ST_PAUSE: if (pauseKey) state_d = ST_PLAY;
         default:  state_d = ST_START;
      endcase
   end

   // Per-frame bookkeeping; pause simply never enters the PLAY branches, which freezes it all.
   always_comb begin
      winner_d     = winner_q;
      overCnt_d    = overCnt_q;
      flash_d      = flash_q;
      prevHealth_d = prevHealth_q;
      if (state_q == ST_START && keyPress) begin
         for (int i = 0; i < NUM_PLAYERS; i++) flash_d[i] = '0;
      end
      if (state_q == ST_PLAY && nf_in) begin
         for (int i = 0; i < NUM_PLAYERS; i++) begin
            prevHealth_d[i] = health[i];
            if (health[i] < prevHealth_q[i]) flash_d[i] = FW'(FLASH_FRAMES);
            else if (flash_q[i] != '0)       flash_d[i] = flash_q[i] - 1'b1;
         end
      end
      if (state_q == ST_PLAY && state_d == ST_OVER) begin
         winner_d  = winnerNext;
         overCnt_d = OCW'(OVER_FRAMES);
      end
      if (state_q == ST_OVER && nf_in && overCnt_q != '0) overCnt_d = overCnt_q - 1'b1;
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         winner_q  <= 2'd0;
         overCnt_q <= '0;
         for (int i = 0; i < NUM_PLAYERS; i++) begin
            flash_q[i]      <= '0;
            prevHealth_q[i] <= '1;
         end
      end else begin
         winner_q     <= winner_d;
         overCnt_q    <= overCnt_d;
         flash_q      <= flash_d;
         prevHealth_q <= prevHealth_d;
      end
   end

   int          hx, vy;
   logic        borderHit_d, barHit_d, saberHit_d, boxHit_d;
   logic [23:0] barColor_d, saberColor_d, boxColor_d, bg_d, overColor_d;
   logic        borderHit_q, barHit_q, saberHit_q, boxHit_q;
   logic [23:0] barColor_q, saberColor_q, boxColor_q, bg_q, overColor_q, startPix_q;
   state_t      stateS1_q;

   assign hx = int'(hcount_in);
   assign vy = int'(vcount_in);

   // Layer decode; loops run high-to-low so the lowest player index ends up winning.
   always_comb begin
      borderHit_d  = (hx == BORDER_X && vy <= BORDER_Y) || (vy == BORDER_Y && hx <= BORDER_X);
      barHit_d     = 1'b0;
      barColor_d   = 24'h0;
      saberHit_d   = 1'b0;
      saberColor_d = 24'h0;
      boxHit_d     = 1'b0;
      boxColor_d   = 24'h0;
      overColor_d  = 24'h0;
      bg_d         = camera_sw ? camera_pixel_in : 24'h0;
      for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
         if (hx >= HB_X0 + i * HB_DX && hx < HB_X0 + i * HB_DX + int'(health[i]) * 16 &&
             vy >= HB_Y && vy < HB_Y + 10) begin
            barHit_d   = 1'b1;
            barColor_d = PLAYER_COLORS[24*i +: 24];
         end
         if (saber_hit_in[i]) begin
            saberHit_d   = 1'b1;
            saberColor_d = saberColor(saber_state_in[2*i +: 2]);
         end
         if (box_hit_in[i]) begin
            boxHit_d   = 1'b1;
            boxColor_d = (flash_q[i] != '0) ? 24'hFFFFFF : PLAYER_COLORS[24*i +: 24];
         end
         if (winner_q == 2'(i)) overColor_d = halve(PLAYER_COLORS[24*i +: 24]);
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         borderHit_q  <= 1'b0;
         barHit_q     <= 1'b0;
         saberHit_q   <= 1'b0;
         boxHit_q     <= 1'b0;
         barColor_q   <= 24'h0;
         saberColor_q <= 24'h0;
         boxColor_q   <= 24'h0;
         bg_q         <= 24'h0;
         overColor_q  <= 24'h0;
         startPix_q   <= 24'h0;
         stateS1_q    <= ST_START;
      end else begin
         borderHit_q  <= borderHit_d;
         barHit_q     <= barHit_d;
         saberHit_q   <= saberHit_d;
         boxHit_q     <= boxHit_d;
         barColor_q   <= barColor_d;
         saberColor_q <= saberColor_d;
         boxColor_q   <= boxColor_d;
         bg_q         <= bg_d;
         overColor_q  <= overColor_d;
         startPix_q   <= start_pixel_in;
         stateS1_q    <= state_q;
      end
   end

   logic [23:0] playPix, pixel_d, pixel_q;

   always_comb begin
      if (borderHit_q)     playPix = 24'hFFFFFF;
      else if (barHit_q)   playPix = barColor_q;
      else if (saberHit_q) playPix = saberColor_q;
      else if (boxHit_q)   playPix = boxColor_q;
      else                 playPix = bg_q;
      case (stateS1_q)
         ST_START: pixel_d = startPix_q;
         ST_PLAY:  pixel_d = playPix;
         ST_OVER:  pixel_d = borderHit_q ? 24'hFFFFFF : overColor_q;
         default:  pixel_d = halve(playPix);
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) pixel_q <= 24'h0;
      else        pixel_q <= pixel_d;
   end

   assign pixel_out  = pixel_q;
   assign state_out  = state_q;
   assign winner_out = winner_q;

endmodule

// File: tb/tb_arena_compositor.sv
// Directed self-checking bench for arena_compositor (two players, slot 0 red, slot 1 blue).
module tb_arena_compositor;

   localparam logic [23:0] COL0 = 24'hFF0000;
   localparam logic [23:0] COL1 = 24'h0000FF;
   localparam logic [31:0] KEY_START = 32'h20DF_5BA4;
   localparam logic [31:0] KEY_ALT   = 32'h20DF_5AA5;
   localparam logic [31:0] KEY_PAUSE = 32'h20DF_10EF;

   logic        clk = 1'b0;
   logic        rst;
   logic        nf;
   logic [10:0] hcount;
   logic [9:0]  vcount;
   logic [31:0] ir;
   logic        irValid;
   logic        cameraSw;
   logic [23:0] cameraPixel, startPixel;
   logic [1:0]  boxHit, saberHit;
   logic [3:0]  saberState;
   logic [5:0]  health;
   logic [23:0] pixel;
   logic [1:0]  state, winner;

   int testsRun = 0;
   int testsFailed = 0;

   arena_compositor #(
      .PLAYER_COLORS({COL1, COL0})
   ) dut (
      .clk_in(clk),
      .rst_in(rst),
      .nf_in(nf),
      .hcount_in(hcount),
      .vcount_in(vcount),
      .ir_in(ir),
      .ir_valid_in(irValid),
      .camera_sw(cameraSw),
      .camera_pixel_in(cameraPixel),
      .start_pixel_in(startPixel),
      .box_hit_in(boxHit),
      .saber_hit_in(saberHit),
      .saber_state_in(saberState),
      .health_in(health),
      .pixel_out(pixel),
      .state_out(state),
      .winner_out(winner)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Drives one pixel's layer inputs and waits out the 2-clock pipeline.
   task automatic applyStimulus(input logic [10:0] h, input logic [9:0] v,
                                input logic [1:0] box, input logic [1:0] sab);
      hcount   = h;
      vcount   = v;
      boxHit   = box;
      saberHit = sab;
      repeat (2) @(negedge clk);
   endtask

   task automatic nfPulse();
      nf = 1'b1;
      @(negedge clk);
      nf = 1'b0;
   endtask

   task automatic irPulse(input logic [31:0] code);
      ir      = code;
      irValid = 1'b1;
      @(negedge clk);
      irValid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; nf = 1'b0; hcount = '0; vcount = '0; ir = '0; irValid = 1'b0;
      cameraSw = 1'b0; cameraPixel = '0; startPixel = '0; boxHit = '0; saberHit = '0;
      saberState = '0; health = {3'd4, 3'd4};
      repeat (2) @(negedge clk);
      checkOutput("reset_state", 32'(state), 32'd0);
      checkOutput("reset_pixel", 32'(pixel), 32'h0);
      checkOutput("reset_winner", 32'(winner), 32'd0);
      rst = 1'b0;

      hcount = 11'd960; vcount = 10'd100; startPixel = 24'h123456;
      @(negedge clk);
      checkOutput("latency_1clk", 32'(pixel), 32'h0);
      @(negedge clk);
      checkOutput("start_pixel", 32'(pixel), 32'h123456);
      checkOutput("start_state", 32'(state), 32'd0);

      ir = KEY_START;
      @(negedge clk);
      checkOutput("ir_not_valid", 32'(state), 32'd0);
      irPulse(32'h1234_5678);
      checkOutput("ir_wrong_key", 32'(state), 32'd0);
      irPulse(KEY_ALT);
      checkOutput("alt_key_play", 32'(state), 32'd1);
      repeat (2) @(negedge clk);
      checkOutput("border_v", 32'(pixel), 32'hFFFFFF);

      applyStimulus(11'd100, 10'd640, 2'b00, 2'b00);
      checkOutput("border_h", 32'(pixel), 32'hFFFFFF);
      applyStimulus(11'd961, 10'd640, 2'b00, 2'b00);
      checkOutput("border_h_end", 32'(pixel), 32'h0);
      applyStimulus(11'd200, 10'd20, 2'b00, 2'b00);
      checkOutput("bar0_first", 32'(pixel), 32'(COL0));
      applyStimulus(11'd263, 10'd29, 2'b00, 2'b00);
      checkOutput("bar0_last", 32'(pixel), 32'(COL0));
      applyStimulus(11'd264, 10'd25, 2'b00, 2'b00);
      checkOutput("bar0_past_end", 32'(pixel), 32'h0);
      applyStimulus(11'd200, 10'd30, 2'b00, 2'b00);
      checkOutput("bar0_below", 32'(pixel), 32'h0);
      applyStimulus(11'd560, 10'd20, 2'b00, 2'b00);
      checkOutput("bar1_first", 32'(pixel), 32'(COL1));

      // First sample after reset sees 4 < 7 in both slots, so both flash; then player 1 drops.
      nfPulse();
      health = {3'd3, 3'd4};
      nfPulse();
      applyStimulus(11'd500, 10'd300, 2'b10, 2'b00);
      checkOutput("flash1_frame1", 32'(pixel), 32'hFFFFFF);
      for (int k = 2; k <= 8; k++) begin
         nfPulse();
         applyStimulus(11'd500, 10'd300, 2'b10, 2'b00);
         checkOutput($sformatf("flash1_frame%0d", k), 32'(pixel), 32'hFFFFFF);
      end
      nfPulse();
      applyStimulus(11'd500, 10'd300, 2'b10, 2'b00);
      checkOutput("flash1_done", 32'(pixel), 32'(COL1));

      saberState = {2'd1, 2'd2};
      applyStimulus(11'd500, 10'd300, 2'b11, 2'b01);
      checkOutput("saber0_state2", 32'(pixel), 32'h0000FF);
      applyStimulus(11'd500, 10'd300, 2'b11, 2'b00);
      checkOutput("box0_wins", 32'(pixel), 32'(COL0));
      applyStimulus(11'd500, 10'd300, 2'b11, 2'b10);
      checkOutput("saber1_state1", 32'(pixel), 32'h00FF00);
      saberState = {2'd1, 2'd0};
      applyStimulus(11'd500, 10'd300, 2'b00, 2'b11);
      checkOutput("saber0_wins", 32'(pixel), 32'hFFFFFF);
      applyStimulus(11'd200, 10'd20, 2'b11, 2'b11);
      checkOutput("bar_over_saber", 32'(pixel), 32'(COL0));
      cameraSw = 1'b1; cameraPixel = 24'h808080;
      applyStimulus(11'd500, 10'd300, 2'b00, 2'b00);
      checkOutput("camera_bg", 32'(pixel), 32'h808080);

      health = {3'd3, 3'd2};
      nfPulse();
      applyStimulus(11'd500, 10'd300, 2'b01, 2'b00);
      checkOutput("flash0_reload", 32'(pixel), 32'hFFFFFF);

`ifdef ARENA_COMPOSITOR_PAUSE_EN
      irPulse(KEY_PAUSE);
      checkOutput("pause_enter", 32'(state), 32'd3);
      applyStimulus(11'd500, 10'd300, 2'b00, 2'b00);
      checkOutput("pause_dim_cam", 32'(pixel), 32'h404040);
      health = {3'd3, 3'd0};
      repeat (3) nfPulse();
      checkOutput("pause_no_over", 32'(state), 32'd3);
      irPulse(KEY_START);
      checkOutput("pause_start_ignored", 32'(state), 32'd3);
      applyStimulus(11'd500, 10'd300, 2'b01, 2'b00);
      checkOutput("pause_dim_flash", 32'(pixel), 32'h7F7F7F);
      health = {3'd3, 3'd2};
      irPulse(KEY_PAUSE);
      checkOutput("pause_exit", 32'(state), 32'd1);
`else
      irPulse(KEY_PAUSE);
      checkOutput("pause_key_ignored", 32'(state), 32'd1);
`endif

      repeat (7) nfPulse();
      applyStimulus(11'd500, 10'd300, 2'b01, 2'b00);
      checkOutput("flash0_last", 32'(pixel), 32'hFFFFFF);
      nfPulse();
      applyStimulus(11'd500, 10'd300, 2'b01, 2'b00);
      checkOutput("flash0_done", 32'(pixel), 32'(COL0));

      cameraSw = 1'b0;
      health = {3'd3, 3'd0};
      nfPulse();
      checkOutput("over_state", 32'(state), 32'd2);
      checkOutput("over_winner1", 32'(winner), 32'd1);
      applyStimulus(11'd500, 10'd300, 2'b11, 2'b11);
      checkOutput("over_pixel", 32'(pixel), 32'h00007F);
      applyStimulus(11'd960, 10'd100, 2'b00, 2'b00);
      checkOutput("over_border", 32'(pixel), 32'hFFFFFF);
      irPulse(KEY_START);
      checkOutput("over_key_ignored", 32'(state), 32'd2);
      repeat (119) nfPulse();
      checkOutput("over_hold_119", 32'(state), 32'd2);
      nfPulse();
      checkOutput("over_to_start", 32'(state), 32'd0);
      startPixel = 24'hABCDEF;
      applyStimulus(11'd500, 10'd300, 2'b00, 2'b00);
      checkOutput("start_again_pixel", 32'(pixel), 32'hABCDEF);

      irPulse(KEY_START);
      checkOutput("start_key_play", 32'(state), 32'd1);
      applyStimulus(11'd500, 10'd300, 2'b01, 2'b00);
      checkOutput("flash_cleared", 32'(pixel), 32'(COL0));
      applyStimulus(11'd200, 10'd20, 2'b00, 2'b00);
      checkOutput("bar0_health0", 32'(pixel), 32'h0);
      health = {3'd0, 3'd0};
      nfPulse();
      checkOutput("over_all_dead", 32'(state), 32'd2);
      checkOutput("winner_all_dead", 32'(winner), 32'd0);
      applyStimulus(11'd500, 10'd300, 2'b00, 2'b00);
      checkOutput("over_pixel0", 32'(pixel), 32'h7F0000);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
